// File: rtl/wb_select_stage.sv
// ---------------------------------------------------------------------------
// wb_select_stage
//   MEM/WB pipeline register with write-back source selection and load
//   byte/half/word/dword extraction (sign or zero extended). Holds on stall,
//   clears on flush, and counts retired (captured, valid) instructions.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   mem_valid           : MEM stage holds a valid instruction
//   alu_result          : ALU result, also the data-memory byte address
//   dmem_read_data      : raw aligned word/dword from data memory
//   pc_plus4, imm       : link value and immediate write-back sources
//   wb_sel              : 0=ALU 1=load 2=PC+4 3=IMM
//   load_size           : 0=byte 1=half 2=word 3=dword
//   load_unsigned       : 1=zero-extend, 0=sign-extend
//   reg_write, rd_addr  : destination write enable and address
//   stall, flush        : hold / kill the instruction being captured
//   wb_valid, wb_reg_write, wb_rd_addr, wb_data : registered write-back
//   wb_misalign_err     : captured load was misaligned or illegal size
//   wb_retire_count     : retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module wb_select_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     dmem_read_data,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     imm,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_misalign_err,
  output logic [CNT_W-1:0]      wb_retire_count
);

  localparam int OB = $clog2(DATA_W / 8);

  logic [OB-1:0]         off;
  logic [DATA_W-1:0]     lane;
  logic                  ld_err;
  logic                  sel_err;
  logic [DATA_W-1:0]     sel_data;

  logic                  valid_q, valid_d;
  logic                  rw_q, rw_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  function automatic logic load_err(input logic [1:0] size, input logic [OB-1:0] o);
    case (size)
      2'd1:    return o[0];
      2'd2:    return (o[1:0] != 2'b00);
      2'd3:    return (DATA_W == 32) || (o != '0);
      default: return 1'b0;
    endcase
  endfunction

  // Extracts the low byte/half/word of the shifted lane and widens it.
  // For a full-width access both extensions coincide, so load_unsigned
  // has no effect there.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] l,
                                               input logic [1:0]        size,
                                               input logic              uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [DATA_W-1:0]  sx;
    logic [DATA_W-1:0]  zx;
    b = l[7:0];
    h = l[15:0];
    w = l[31:0];
    case (size)
      2'd0: begin
        sx = DATA_W'(b);
        zx = DATA_W'(l[7:0]);
      end
      2'd1: begin
        sx = DATA_W'(h);
        zx = DATA_W'(l[15:0]);
      end
      2'd2: begin
        sx = DATA_W'(w);
        zx = DATA_W'(l[31:0]);
      end
      default: begin
        sx = l;
        zx = l;
      end
    endcase
    return uns ? zx : sx;
  endfunction

  assign off     = alu_result[OB-1:0];
  assign lane    = dmem_read_data >> {off, 3'b000};
  assign ld_err  = load_err(load_size, off);
  assign sel_err = (wb_sel == 2'd1) && ld_err;

  always_comb begin
    sel_data = alu_result;
    case (wb_sel)
      2'd0: sel_data = alu_result;
      // A faulting load returns the raw memory word for trap diagnosis.
      2'd1: sel_data = ld_err ? dmem_read_data : extend(lane, load_size, load_unsigned);
      2'd2: sel_data = pc_plus4;
      2'd3: sel_data = imm;
      default: sel_data = alu_result;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      rd_d    = '0;
      data_d  = '0;
      err_d   = 1'b0;
    end else if (!stall) begin
      valid_d = mem_valid;
      rd_d    = rd_addr;
      data_d  = sel_data;
      err_d   = mem_valid && sel_err;
      // x0 is never written, but the instruction still retires.
      rw_d    = mem_valid && reg_write && (rd_addr != '0) && !sel_err;
      if (mem_valid) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---- MEM -> WB register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_valid        = valid_q;
  assign wb_reg_write    = rw_q;
  assign wb_rd_addr      = rd_q;
  assign wb_data         = data_q;
  assign wb_misalign_err = err_q;
  assign wb_retire_count = cnt_q;

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_valid, load_unsigned, reg_write, stall, flush;
  logic [1:0]  wb_sel, load_size;
  logic [4:0]  rd_addr;
  logic [63:0] alu, dmem, pc, imm;

  logic        va, rwa, ea;
  logic [4:0]  rda;
  logic [31:0] da, ca;
  logic        vb, rwb, eb;
  logic [4:0]  rdb;
  logic [63:0] db;
  logic [3:0]  cb;

  wb_select_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) u_a (
    .clk(clk), .reset(reset), .mem_valid(mem_valid),
    .alu_result(alu[31:0]), .dmem_read_data(dmem[31:0]),
    .pc_plus4(pc[31:0]), .imm(imm[31:0]),
    .wb_sel(wb_sel), .load_size(load_size), .load_unsigned(load_unsigned),
    .reg_write(reg_write), .rd_addr(rd_addr), .stall(stall), .flush(flush),
    .wb_valid(va), .wb_reg_write(rwa), .wb_rd_addr(rda), .wb_data(da),
    .wb_misalign_err(ea), .wb_retire_count(ca)
  );

  wb_select_stage #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .mem_valid(mem_valid),
    .alu_result(alu), .dmem_read_data(dmem),
    .pc_plus4(pc), .imm(imm),
    .wb_sel(wb_sel), .load_size(load_size), .load_unsigned(load_unsigned),
    .reg_write(reg_write), .rd_addr(rd_addr), .stall(stall), .flush(flush),
    .wb_valid(vb), .wb_reg_write(rwb), .wb_rd_addr(rdb), .wb_data(db),
    .wb_misalign_err(eb), .wb_retire_count(cb)
  );

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] d;
    logic        e;
    logic [31:0] c;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];
  obs_t got, exp_o;
  int npass = 0;
  int ntotal = 0;
  logic [31:0] cnt_a = '0;
  logic [3:0]  cnt_b = '0;

  function automatic obs_t mk(logic v, logic rw, logic [4:0] rd, logic [63:0] d,
                              logic e, logic [31:0] c);
    obs_t o;
    o.v = v; o.rw = rw; o.rd = rd; o.d = d; o.e = e; o.c = c;
    return o;
  endfunction

  function automatic obs_t obs_a();
    return mk(va, rwa, rda, {32'b0, da}, ea, ca);
  endfunction

  function automatic obs_t obs_b();
    return mk(vb, rwb, rdb, db, eb, {28'b0, cb});
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("v=%0b rw=%0b rd=%0d data=%h err=%0b cnt=%0d",
                     o.v, o.rw, o.rd, o.d, o.e, o.c);
  endfunction

  function automatic logic capt();
    return !reset && !flush && !stall && mem_valid;
  endfunction

  function automatic logic [31:0] nxt_a();
    if (reset) return 32'd0;
    return capt() ? cnt_a + 32'd1 : cnt_a;
  endfunction

  function automatic logic [31:0] nxt_b();
    logic [3:0] n;
    if (reset) return 32'd0;
    n = capt() ? cnt_b + 4'd1 : cnt_b;
    return {28'b0, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    cnt_a = nxt_a();
    cnt_b = nxt_b()[3:0];
    #1;
  endtask

  task automatic drive(logic mv, logic [1:0] sel, logic [1:0] sz, logic uns,
                       logic rw, logic [4:0] rd, logic [63:0] a, logic [63:0] d);
    mem_valid = mv; wb_sel = sel; load_size = sz; load_unsigned = uns;
    reg_write = rw; rd_addr = rd; alu = a; dmem = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc = '0; imm = '0;
    drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    qa.push_back(mk(0, 0, 0, 0, 0, 0));
    qb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL reset_a: got %s required %s", fmt(got), fmt(exp_o)); else npass++;
    got = obs_b(); exp_o = qb.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL reset_b: got %s required %s", fmt(got), fmt(exp_o)); else npass++;

    reset = 1'b0;
    drive(1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 5'd5, 64'h1234, 64'd0);
    qa.push_back(mk(1, 1, 5, 64'h1234, 0, nxt_a()));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL capture_alu: got %s required %s", fmt(got), fmt(exp_o)); else npass++;

    reset = 1'b1;
    qa.push_back(mk(0, 0, 0, 0, 0, 0));
    qb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL reset_mid_a: got %s required %s", fmt(got), fmt(exp_o)); else npass++;
    got = obs_b(); exp_o = qb.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL reset_mid_b: got %s required %s", fmt(got), fmt(exp_o)); else npass++;
    reset = 1'b0;
  endtask

  task automatic test_load32();
    logic [31:0] addr [6] = '{32'h100, 32'h101, 32'h102, 32'h100, 32'h100, 32'h103};
    logic [1:0]  sz   [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
    logic        uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] res  [6] = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1,
                              32'h80F1_7F82, 32'h0000_7F82, 32'hFFFF_FF80};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd1, sz[i], uns[i], 1'b1, 5'd3, {32'b0, addr[i]}, 64'h80F1_7F82);
      qa.push_back(mk(1, 1, 3, {32'b0, res[i]}, 0, nxt_a()));
      tick();
      got = obs_a(); exp_o = qa.pop_front(); ntotal++;
      if (got !== exp_o) $display("FAIL load32_%0d: got %s required %s", i, fmt(got), fmt(exp_o)); else npass++;
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 5'd7, 64'h103, 64'h80F1_7F82);
    qa.push_back(mk(1, 0, 7, 64'h80F1_7F82, 1, nxt_a()));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL misalign_half: got %s required %s", fmt(got), fmt(exp_o)); else npass++;

    // dword is illegal at 32 bits even when aligned
    drive(1'b1, 2'd1, 2'd3, 1'b0, 1'b1, 5'd8, 64'h100, 64'h80F1_7F82);
    qa.push_back(mk(1, 0, 8, 64'h80F1_7F82, 1, nxt_a()));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL dword_on_32: got %s required %s", fmt(got), fmt(exp_o)); else npass++;

    // a bubble carrying a misaligned address raises no error
    drive(1'b0, 2'd1, 2'd2, 1'b0, 1'b1, 5'd7, 64'h102, 64'h80F1_7F82);
    qa.push_back(mk(0, 0, 7, 64'h80F1_7F82, 0, nxt_a()));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL misalign_bubble: got %s required %s", fmt(got), fmt(exp_o)); else npass++;
  endtask

  task automatic test_stall_flush();
    obs_t held;
    drive(1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 5'd9, 64'hAAAA, 64'd0);
    held = mk(1, 1, 9, 64'hAAAA, 0, nxt_a());
    qa.push_back(held);
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL stall_pre: got %s required %s", fmt(got), fmt(exp_o)); else npass++;

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 2'd0, 1'b0, 1'b1, 5'(i + 10), 64'(i + 64'h77), 64'h1);
      pc = 64'(i); imm = 64'(i + 5);
      qa.push_back(held);
      tick();
      got = obs_a(); exp_o = qa.pop_front(); ntotal++;
      if (got !== exp_o) $display("FAIL stall_hold_%0d: got %s required %s", i, fmt(got), fmt(exp_o)); else npass++;
    end

    flush = 1'b1;
    drive(1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 5'd12, 64'hBBBB, 64'd0);
    qa.push_back(mk(0, 0, 0, 0, 0, cnt_a));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL stall_flush: got %s required %s", fmt(got), fmt(exp_o)); else npass++;

    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd4, 64'h55, 64'd0);
    qa.push_back(mk(0, 0, 4, 64'h55, 0, cnt_a));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL bubble: got %s required %s", fmt(got), fmt(exp_o)); else npass++;

    flush = 1'b1;
    drive(1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 5'd6, 64'h66, 64'd0);
    qa.push_back(mk(0, 0, 0, 0, 0, cnt_a));
    tick();
    got = obs_a(); exp_o = qa.pop_front(); ntotal++;
    if (got !== exp_o) $display("FAIL flush_only: got %s required %s", fmt(got), fmt(exp_o)); else npass++;
    flush = 1'b0;
  endtask

  task automatic test_sources();
    logic [1:0]  sel [4] = '{2'd2, 2'd2, 2'd3, 2'd0};
    logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd3, 2'd1};
    logic [4:0]  rd  [4] = '{5'd1, 5'd0, 5'd2, 5'd31};
    logic        wr  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] res [4] = '{32'h104, 32'h104, 32'hABCD_E000, 32'h13};
    pc = 64'h104; imm = 64'hABCD_E000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, sel[i], sz[i], 1'b0, 1'b1, rd[i], 64'h13, 64'hFFFF_FFFF);
      qa.push_back(mk(1, wr[i], rd[i], {32'b0, res[i]}, 0, nxt_a()));
      tick();
      got = obs_a(); exp_o = qa.pop_front(); ntotal++;
      if (got !== exp_o) $display("FAIL source_%0d: got %s required %s", i, fmt(got), fmt(exp_o)); else npass++;
    end
  endtask

  task automatic test_wide();
    logic [63:0] addr [5] = '{64'h1000, 64'h1004, 64'h1004, 64'h1007, 64'h1004};
    logic [1:0]  sz   [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd3};
    logic        uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] d    [5] = '{64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_1234_5678,
                              64'hDEAD_BEEF_1234_5678, 64'hDEAD_BEEF_1234_5678,
                              64'hDEAD_BEEF_1234_5678};
    logic [63:0] res  [5] = '{64'h0123_4567_89AB_CDEF, 64'h0000_0000_DEAD_BEEF,
                              64'hFFFF_FFFF_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFDE,
                              64'hDEAD_BEEF_1234_5678};
    logic        er   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd1, sz[i], uns[i], 1'b1, 5'd11, addr[i], d[i]);
      qb.push_back(mk(1, !er[i], 11, res[i], er[i], nxt_b()));
      tick();
      got = obs_b(); exp_o = qb.pop_front(); ntotal++;
      if (got !== exp_o) $display("FAIL load64_%0d: got %s required %s", i, fmt(got), fmt(exp_o)); else npass++;
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 5'd2, 64'(i), 64'd0);
      qb.push_back(mk(1, 1, 2, 64'(i), 0, nxt_b()));
      tick();
      exp_o = qb.pop_front();
      if (i == 16) begin
        got = obs_b(); ntotal++;
        if (got.c !== 32'd1) $display("FAIL count_wrap: got cnt=%0d required cnt=1", got.c); else npass++;
      end else if (i == 15) begin
        got = obs_b(); ntotal++;
        if (got.c !== 32'd0) $display("FAIL count_wrap_zero: got cnt=%0d required cnt=0", got.c); else npass++;
      end
      got = obs_b(); ntotal++;
      if (got !== exp_o) $display("FAIL b2b_%0d: got %s required %s", i, fmt(got), fmt(exp_o)); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_load32();
    test_misalign();
    test_stall_flush();
    test_sources();
    test_wide();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised MEM/WB pipeline register combined with a write-back source selector; successor to the single-bit ALU/memory write-back mux.
- Selects one of four write-back sources and performs load byte/half/word(/dword) extraction with sign or zero extension.
- Registers the result with stall and flush control, and maintains a retired-instruction counter.
- Sits between the data-memory stage and the register file; its outputs also feed the forwarding unit.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64.
REG_ADDR_W, 5, register-file address width.
CNT_W, 32, retired-instruction counter width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
mem_valid  input  1  MEM stage holds a valid instruction.
alu_result  input  DATA_W  ALU result; also the data-memory byte address.
dmem_read_data  input  DATA_W  raw aligned word/dword read from data memory.
pc_plus4  input  DATA_W  link value.
imm  input  DATA_W  immediate (LUI-type write-back).
wb_sel  input  2  0=ALU, 1=MEM load, 2=PC+4, 3=IMM.
load_size  input  2  0=byte, 1=half, 2=word, 3=dword.
load_unsigned  input  1  1=zero-extend, 0=sign-extend.
reg_write  input  1  instruction writes rd.
rd_addr  input  REG_ADDR_W  destination register.
stall  input  1  hold WB registers.
flush  input  1  kill the instruction being captured.
wb_valid  output  1  registered valid.
wb_reg_write  output  1  register-file write enable.
wb_rd_addr  output  REG_ADDR_W  register-file write address.
wb_data  output  DATA_W  register-file write data.
wb_misalign_err  output  1  captured load was misaligned or of an illegal size.
wb_retire_count  output  CNT_W  count of retired instructions.

Behaviour:
- Latency: exactly one cycle from MEM inputs to wb_* outputs. All wb_* outputs are registers; there are no combinational paths from inputs to outputs.
- Reset: while reset=1 at a clock edge, all outputs go to 0, including wb_retire_count.
- Update priority per edge: reset > flush > stall > capture.
- flush=1: wb_valid, wb_reg_write and wb_misalign_err go to 0. wb_rd_addr and wb_data go to 0. The counter is unchanged. flush overrides stall.
- stall=1 (flush=0): all wb_* registers and the counter hold their values.
- capture (stall=0, flush=0):
  - wb_valid <= mem_valid.
  - wb_rd_addr <= rd_addr.
  - wb_data <= selected value.
  - wb_misalign_err <= mem_valid & (wb_sel==1) & err.
  - wb_reg_write <= mem_valid & reg_write & (rd_addr!=0) & ~(wb_sel==1 & err).
- Byte offset: off = alu_result[OB-1:0], where OB = log2(DATA_W/8); OB=2 for DATA_W=32, OB=3 for DATA_W=64.
- Load extraction: lane = dmem_read_data >> (8*off).
  - byte: lane[7:0].
  - half: lane[15:0].
  - word: lane[31:0].
  - dword: full lane.
  - Each is extended to DATA_W by sign (load_unsigned=0) or zero (load_unsigned=1). load_unsigned is ignored when size equals DATA_W.
- err conditions:
  - half with off[0]=1.
  - word with off[1:0]!=0.
  - dword with off!=0.
  - dword when DATA_W=32.
  - On err, wb_data <= the unshifted dmem_read_data.
- wb_sel 0/2/3 pass alu_result, pc_plus4 or imm unchanged; load_size and load_unsigned are ignored for these.
- Counter: increments by 1 on each capture edge with mem_valid=1. It does not increment on flush or stall. It wraps from 2^CNT_W-1 to 0 silently.
- Writes to x0: wb_reg_write is forced to 0, but wb_valid and wb_data are captured normally and the counter still increments.
- No X propagation: unused inputs may be X only when mem_valid=0 and wb_valid=0.

Test Plan:
- Reset mid-stream:
  - Stimulus: capture ALU 0x1234 into rd=5, then reset=1 for one edge.
  - Required response: all outputs read 0 on the next cycle, including the counter.
- Load extraction, DATA_W=32, dmem_read_data=0x80F1_7F82:
  - byte off=0, signed -> 0xFFFF_FF82.
  - byte off=1, unsigned -> 0x0000_007F.
  - half off=2, signed -> 0xFFFF_80F1.
  - word off=0 -> 0x80F1_7F82.
- Misalignment:
  - Stimulus: half load with off=3, reg_write=1, rd=7.
  - Required response: wb_misalign_err=1, wb_reg_write=0, wb_data=0x80F1_7F82, counter +1.
- Stall/flush priority:
  - Stimulus: stall=1 for 3 cycles while inputs change.
  - Required response: outputs hold.
  - Stimulus: stall=1 together with flush=1.
  - Required response: wb_valid=0, wb_reg_write=0, counter unchanged.
- Sources and x0:
  - Stimulus: wb_sel=2 with pc_plus4=0x104, rd=1.
  - Required response: wb_data=0x104, wb_reg_write=1.
  - Stimulus: same with rd=0.
  - Required response: wb_reg_write=0, wb_valid=1.
- Counter wrap and DATA_W=64:
  - Stimulus: CNT_W=4, 17 valid captures.
  - Required response: count=1.
  - Stimulus: DATA_W=64, dword off=0.
  - Required response: full value passes unchanged.
  - Stimulus: DATA_W=64, word off=4, unsigned, upper half 0xDEAD_BEEF.
  - Required response: 0x0000_0000_DEAD_BEEF.
